// File: rtl/cmip_rst_pkg.sv
// cmip_rst_seq shared types and helpers.
// State encoding and counter sizing.
package cmip_rst_pkg;

  typedef enum logic [1:0] {
    HOLD      = 2'd0,
    WAIT_LOCK = 2'd1,
    RELEASE   = 2'd2,
    DONE      = 2'd3
  } state_e;

  // Bits needed to hold max_cnt, never less than one.
  function automatic int cnt_w(input int max_cnt);
    int w;
    w = $clog2(max_cnt + 1);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/cmip_lock_filt.sv
// Lock input synchronizer plus
// consecutive-high qualification filter.
module cmip_lock_filt
  import cmip_rst_pkg::*;
#(
  parameter int LOCK_FILT = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_lock,
  output logic o_lk_s,
  output logic o_lock_ok
);

  localparam int CW = cnt_w(LOCK_FILT);
  localparam logic [CW-1:0] FILT_MAX =
    CW'(LOCK_FILT);

  logic          sync1_q;
  logic          sync2_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Filter counts synchronized-high cycles, saturating.
  always_comb begin
    cnt_d = cnt_q;
    if (!sync2_q)
      cnt_d = '0;
    else if (cnt_q != FILT_MAX)
      cnt_d = cnt_q + 1'b1;
  end

  // Two-flop synchronizer and filter register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= i_lock;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
    end
  end

  assign o_lk_s    = sync2_q;
  assign o_lock_ok = (cnt_q == FILT_MAX);

endmodule

// File: rtl/cmip_rst_seq.sv
// Staged reset sequencer: holds, waits for lock,
// then releases resets one by one with a fixed gap.
module cmip_rst_seq
  import cmip_rst_pkg::*;
#(
  parameter int RST_NUM   = 4,
  parameter int HOLD_CYC  = 16,
  parameter int GAP_CYC   = 8,
  parameter int LOCK_FILT = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_lock,
  input  logic               i_soft_rst,
  output logic [RST_NUM-1:0] o_rst_n,
  output logic               o_rst_done
);

  localparam int HW = cnt_w(HOLD_CYC - 1);
  localparam int GW = cnt_w(GAP_CYC - 1);
  localparam logic [HW-1:0] HOLD_MAX =
    HW'(HOLD_CYC - 1);
  localparam logic [GW-1:0] GAP_MAX =
    GW'(GAP_CYC - 1);
  localparam logic [RST_NUM-1:0] ONE =
    RST_NUM'(1);

  state_e             state_q, state_d;
  logic [HW-1:0]      hold_q, hold_d;
  logic [GW-1:0]      gap_q, gap_d;
  logic [RST_NUM-1:0] rst_n_q, rst_n_d;
  logic               done_q, done_d;
  logic               lk_s;
  logic               lock_ok;
  logic               restart;

  cmip_lock_filt #(
    .LOCK_FILT (LOCK_FILT)
  ) u_lock_filt (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_lock    (i_lock),
    .o_lk_s    (lk_s),
    .o_lock_ok (lock_ok)
  );

  // Lock loss only matters once releasing has begun.
  assign restart = i_soft_rst |
    (!lk_s && (state_q == RELEASE ||
               state_q == DONE));

  // Next-state, counters and staged outputs.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    rst_n_d = rst_n_q;
    done_d  = done_q;
    if (restart) begin
      state_d = HOLD;
      hold_d  = '0;
      gap_d   = '0;
      rst_n_d = '0;
      done_d  = 1'b0;
    end else begin
      unique case (state_q)
        HOLD: begin
          if (hold_q == HOLD_MAX) begin
            state_d = WAIT_LOCK;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
        WAIT_LOCK: begin
          if (lock_ok) begin
            state_d = RELEASE;
            rst_n_d = ONE;
            gap_d   = '0;
          end
        end
        RELEASE: begin
          if (&rst_n_q) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else if (gap_q == GAP_MAX) begin
            gap_d   = '0;
            rst_n_d = (rst_n_q << 1) | ONE;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
        DONE: begin
          done_d = 1'b1;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= HOLD;
      hold_q  <= '0;
      gap_q   <= '0;
      rst_n_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
      rst_n_q <= rst_n_d;
      done_q  <= done_d;
    end
  end

  assign o_rst_n    = rst_n_q;
  assign o_rst_done = done_q;

endmodule

// File: tb/tb_cmip_rst_seq.sv
// Directed bench for cmip_rst_seq.
// Cycle n = state after n edges with i_rst low.
module tb_cmip_rst_seq;

  logic       clk;
  logic       i_rst;
  logic       i_lock;
  logic       i_soft_rst;
  logic [3:0] o_rst_n;
  logic       o_rst_done;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit mon_en = 0;

  cmip_rst_seq dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_lock     (i_lock),
    .i_soft_rst (i_soft_rst),
    .o_rst_n    (o_rst_n),
    .o_rst_done (o_rst_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Thermometer shape and done consistency.
  always @(negedge clk) begin
    if (mon_en) begin
      n_chk++;
      if ((((o_rst_n + 4'd1) & o_rst_n) != 4'd0) ||
          (o_rst_done && !(&o_rst_n))) begin
        n_fail++;
        $display("FAIL invariant t=%0t o_rst_n=%b done=%b",
                 $time, o_rst_n, o_rst_done);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic go_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic do_reset(input logic lk);
    i_lock     = lk;
    i_soft_rst = 1'b0;
    i_rst      = 1'b1;
    repeat (3) tick();
    i_rst = 1'b0;
    cyc   = 0;
  endtask

  task automatic test_reset();
    i_lock     = 1'b1;
    i_soft_rst = 1'b0;
    i_rst      = 1'b1;
    repeat (2) tick();
    mon_en = 1;
    n_chk++;
    if (o_rst_n !== 4'b0000 || o_rst_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold got %b/%b expected 0000/0",
               o_rst_n, o_rst_done);
    end
    i_rst = 1'b0;
    cyc   = 0;
    n_chk++;
    if (o_rst_n !== 4'b0000 || o_rst_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_cyc0 got %b/%b expected 0000/0",
               o_rst_n, o_rst_done);
    end
  endtask

  task automatic test_default_seq();
    int         cy[10] = '{16, 17, 24, 25, 32,
                           33, 40, 41, 42, 45};
    logic [3:0] ex[10] = '{4'h0, 4'h1, 4'h1, 4'h3, 4'h3,
                           4'h7, 4'h7, 4'hF, 4'hF, 4'hF};
    logic       ed[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
    do_reset(1'b1);
    for (int i = 0; i < 10; i++) begin
      go_to(cy[i]);
      n_chk++;
      if (o_rst_n !== ex[i] || o_rst_done !== ed[i]) begin
        n_fail++;
        $display("FAIL default_seq cyc=%0d got %b/%b expected %b/%b",
                 cyc, o_rst_n, o_rst_done, ex[i], ed[i]);
      end
    end
  endtask

  task automatic test_late_lock();
    int         cy[6] = '{20, 36, 37, 45, 61, 62};
    logic [3:0] ex[6] = '{4'h0, 4'h0, 4'h1, 4'h3, 4'hF, 4'hF};
    logic       ed[6] = '{0, 0, 0, 0, 0, 1};
    do_reset(1'b0);
    go_to(30);
    i_lock = 1'b1;
    for (int i = 0; i < 6; i++) begin
      go_to(cy[i]);
      n_chk++;
      if (o_rst_n !== ex[i] || o_rst_done !== ed[i]) begin
        n_fail++;
        $display("FAIL late_lock cyc=%0d got %b/%b expected %b/%b",
                 cyc, o_rst_n, o_rst_done, ex[i], ed[i]);
      end
    end
  endtask

  task automatic test_lock_loss();
    int         cy[6] = '{72, 73, 89, 90, 114, 115};
    logic [3:0] ex[6] = '{4'hF, 4'h0, 4'h0, 4'h1, 4'hF, 4'hF};
    logic       ed[6] = '{1, 0, 0, 0, 0, 1};
    go_to(70);
    i_lock = 1'b0;
    tick();
    i_lock = 1'b1;
    for (int i = 0; i < 6; i++) begin
      go_to(cy[i]);
      n_chk++;
      if (o_rst_n !== ex[i] || o_rst_done !== ed[i]) begin
        n_fail++;
        $display("FAIL lock_loss cyc=%0d got %b/%b expected %b/%b",
                 cyc, o_rst_n, o_rst_done, ex[i], ed[i]);
      end
    end
  endtask

  task automatic test_soft_rst();
    int         cy[5] = '{26, 42, 43, 67, 68};
    logic [3:0] ex[5] = '{4'h0, 4'h0, 4'h1, 4'hF, 4'hF};
    logic       ed[5] = '{0, 0, 0, 0, 1};
    do_reset(1'b1);
    go_to(25);
    n_chk++;
    if (o_rst_n !== 4'h3) begin
      n_fail++;
      $display("FAIL soft_pre got %b expected 0011", o_rst_n);
    end
    i_soft_rst = 1'b1;
    tick();
    i_soft_rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      go_to(cy[i]);
      n_chk++;
      if (o_rst_n !== ex[i] || o_rst_done !== ed[i]) begin
        n_fail++;
        $display("FAIL soft_rst cyc=%0d got %b/%b expected %b/%b",
                 cyc, o_rst_n, o_rst_done, ex[i], ed[i]);
      end
    end
  endtask

  task automatic test_soft_held();
    int         cy[3] = '{75, 91, 92};
    logic [3:0] ex[3] = '{4'h0, 4'h0, 4'h1};
    go_to(70);
    i_soft_rst = 1'b1;
    go_to(75);
    i_soft_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      go_to(cy[i]);
      n_chk++;
      if (o_rst_n !== ex[i] || o_rst_done !== 1'b0) begin
        n_fail++;
        $display("FAIL soft_held cyc=%0d got %b/%b expected %b/0",
                 cyc, o_rst_n, o_rst_done, ex[i]);
      end
    end
  endtask

  task automatic test_glitch_hold();
    int         cy[7] = '{14, 16, 19, 20, 28, 44, 45};
    logic [3:0] ex[7] = '{4'h0, 4'h0, 4'h0, 4'h1,
                          4'h3, 4'hF, 4'hF};
    logic       ed[7] = '{0, 0, 0, 0, 0, 0, 1};
    do_reset(1'b1);
    go_to(12);
    i_lock = 1'b0;
    tick();
    i_lock = 1'b1;
    for (int i = 0; i < 7; i++) begin
      go_to(cy[i]);
      n_chk++;
      if (o_rst_n !== ex[i] || o_rst_done !== ed[i]) begin
        n_fail++;
        $display("FAIL glitch_hold cyc=%0d got %b/%b expected %b/%b",
                 cyc, o_rst_n, o_rst_done, ex[i], ed[i]);
      end
    end
  endtask

  task automatic test_rst_mid_release();
    do_reset(1'b1);
    go_to(30);
    n_chk++;
    if (o_rst_n !== 4'h3) begin
      n_fail++;
      $display("FAIL mid_pre got %b expected 0011", o_rst_n);
    end
    i_rst      = 1'b1;
    i_soft_rst = 1'b1;
    tick();
    n_chk++;
    if (o_rst_n !== 4'h0 || o_rst_done !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rst got %b/%b expected 0000/0",
               o_rst_n, o_rst_done);
    end
    i_soft_rst = 1'b0;
    tick();
    i_rst = 1'b0;
    cyc   = 0;
    go_to(16);
    n_chk++;
    if (o_rst_n !== 4'h0) begin
      n_fail++;
      $display("FAIL mid_replay16 got %b expected 0000", o_rst_n);
    end
    go_to(17);
    n_chk++;
    if (o_rst_n !== 4'h1) begin
      n_fail++;
      $display("FAIL mid_replay17 got %b expected 0001", o_rst_n);
    end
  endtask

  initial begin
    i_rst      = 1'b1;
    i_lock     = 1'b0;
    i_soft_rst = 1'b0;
    test_reset();
    test_default_seq();
    test_late_lock();
    test_lock_loss();
    test_soft_rst();
    test_soft_held();
    test_glitch_hold();
    test_rst_mid_release();
    mon_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
